// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and a sign-extension helper for word-form results.
package mdu_pkg;

    localparam logic [3:0] OP_MUL    = 4'b0000;
    localparam logic [3:0] OP_MULH   = 4'b0001;
    localparam logic [3:0] OP_MULHSU = 4'b0010;
    localparam logic [3:0] OP_MULHU  = 4'b0011;
    localparam logic [3:0] OP_DIV    = 4'b0100;
    localparam logic [3:0] OP_DIVU   = 4'b0101;
    localparam logic [3:0] OP_REM    = 4'b0110;
    localparam logic [3:0] OP_REMU   = 4'b0111;
    localparam logic [3:0] OP_MULW   = 4'b1000;
    localparam logic [3:0] OP_DIVW   = 4'b1100;
    localparam logic [3:0] OP_DIVUW  = 4'b1101;
    localparam logic [3:0] OP_REMW   = 4'b1110;
    localparam logic [3:0] OP_REMUW  = 4'b1111;

    localparam int MAX_DW = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // Replicates bit dw/2-1 into every bit above it; callers cast to their width.
    function automatic logic [MAX_DW-1:0] sext_half(input logic [MAX_DW-1:0] v, input int dw);
        logic [MAX_DW-1:0] r;
        r = v;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i >= dw / 2) r[i] = v[dw/2-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, subtract the
// divisor when it fits and shift the resulting quotient bit in at the bottom.
module mdu_div_step #(
    parameter int DW = 64
) (
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] quo,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_next,
    output logic [DW-1:0] quo_next
);
    logic [DW:0]   shifted;
    logic [DW-1:0] rem_sub;
    logic          fits;

    assign shifted  = {rem, quo[DW-1]};
    assign fits     = (shifted >= {1'b0, divisor});
    // When the divisor fits, the true difference is below 2^DW, so DW bits suffice.
    assign rem_sub  = shifted[DW-1:0] - divisor;
    assign rem_next = fits ? rem_sub : shifted[DW-1:0];
    assign quo_next = {quo[DW-2:0], fits};
endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV64M multiply/divide unit with valid/ready handshakes.
// Define MDU_EARLY_OUT_EN to let zero operands and zero divisors skip the iterations.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic          busy
);
    localparam int CW = $clog2(DW) + 1;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [3:0]      op_r;
    logic [DW-1:0]   a_r, b_r, hi, lo, opnd, result_r;
    logic            neg_r;

    logic            word, is_div, illegal, a_sgn, b_sgn, sa, sb, neg_p, early;
    logic [2:0]      f3;
    logic [DW-1:0]   ext_a, ext_b, mag_a, mag_b, hi_p, lo_p, opnd_p;
    logic [DW-1:0]   div_hi, div_lo, quo_fix, rem_fix, res_sel, fix_res;
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] prod;

    assign word    = op_r[3];
    assign f3      = op_r[2:0];
    assign is_div  = f3[2];
    assign illegal = word & ~is_div & (op_r != OP_MULW);
    assign a_sgn   = (is_div ? ~f3[0] : (f3 != OP_MULHU[2:0])) & ~(word & ~is_div);
    assign b_sgn   = (is_div ? ~f3[0] : ~f3[1]) & ~(word & ~is_div);

    // Operand preparation: word extension, magnitudes, result sign, iteration preload.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ext_a = a_r;
        ext_b = b_r;
        if (word) begin
            ext_a = a_sgn ? DW'(sext_half(MAX_DW'(a_r), DW)) : {{(DW/2){1'b0}}, a_r[DW/2-1:0]};
            ext_b = b_sgn ? DW'(sext_half(MAX_DW'(b_r), DW)) : {{(DW/2){1'b0}}, b_r[DW/2-1:0]};
        end
        sa    = a_sgn & ext_a[DW-1];
        sb    = b_sgn & ext_b[DW-1];
        mag_a = sa ? -ext_a : ext_a;
        mag_b = sb ? -ext_b : ext_b;

        if (!is_div)     neg_p = sa ^ sb;
        else if (!f3[1]) neg_p = (sa ^ sb) & (ext_b != '0);
        else             neg_p = sa;

        hi_p   = '0;
        lo_p   = is_div ? (word ? {mag_a[DW/2-1:0], {(DW/2){1'b0}}} : mag_a) : mag_b;
        opnd_p = is_div ? mag_b : mag_a;
        early  = 1'b0;
`ifdef MDU_EARLY_OUT_EN
        // Preload exactly what the full iteration would have left behind.
        if (!illegal) begin
            if (is_div && ext_b == '0) begin
                hi_p  = mag_a;
                lo_p  = '1;
                early = 1'b1;
            end else if (ext_a == '0 || ext_b == '0) begin
                hi_p  = '0;
                lo_p  = '0;
                early = 1'b1;
            end
        end
`endif
    end

    mdu_div_step #(.DW(DW)) u_div_step (
        .rem      (hi),
        .quo      (lo),
        .divisor  (opnd),
        .rem_next (div_hi),
        .quo_next (div_lo)
    );

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

    // Word multiplies run DW/2 steps, so their product sits DW/2 bits up in {hi,lo}.
    assign prod    = neg_r ? -{hi, lo} : {hi, lo};
    assign quo_fix = neg_r ? -lo : lo;
    assign rem_fix = neg_r ? -hi : hi;

    always_comb begin
        case (f3)
            OP_MUL[2:0]:                               res_sel = word ? prod[DW+DW/2-1:DW/2] : prod[DW-1:0];
            OP_MULH[2:0], OP_MULHSU[2:0], OP_MULHU[2:0]: res_sel = prod[2*DW-1:DW];
            OP_DIV[2:0], OP_DIVU[2:0]:                 res_sel = quo_fix;
            default:                                   res_sel = rem_fix;
        endcase
        fix_res = word ? DW'(sext_half(MAX_DW'(res_sel), DW)) : res_sel;
        if (illegal) fix_res = '0;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (in_valid) state_n = S_PREP;
            S_PREP:  state_n = early ? S_FIX : S_CALC;
            S_CALC:  if (cnt == CW'(1)) state_n = S_FIX;
            S_FIX:   state_n = S_DONE;
            S_DONE:  if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush && state != S_IDLE) state_n = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg_r    <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_r <= op;
                    a_r  <= op_a;
                    b_r  <= op_b;
                end
                S_PREP: begin
                    hi    <= hi_p;
                    lo    <= lo_p;
                    opnd  <= opnd_p;
                    neg_r <= neg_p;
                    cnt   <= word ? CW'(DW / 2) : CW'(DW);
                end
                S_CALC: begin
                    if (is_div) begin
                        hi <= div_hi;
                        lo <= div_lo;
                    end else begin
                        hi <= mul_sum[DW:1];
                        lo <= {mul_sum[0], lo[DW-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                end
                S_FIX: if (!flush) result_r <= fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign result    = result_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV64M corner cases plus random ops
// compared against an arithmetic reference model, with latency and handshake checks.
module tb_mdu_iter;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  op;
    logic [63:0] op_a, op_b, result;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mdu_iter #(.DW(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural RV64M result, straight from the ISA arithmetic rules.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ub;
        logic [127:0] p;
        logic [31:0]  a32, b32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        sa  = $signed(a);
        sb  = $signed(b);
        ub  = {64'd0, b};
        r32 = '0;
        case (o)
            4'h0: return a * b;
            4'h1: begin p = sa * sb; return p[127:64]; end
            4'h2: begin p = sa * ub; return p[127:64]; end
            4'h3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4'h4: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return MIN64;
                return $signed(a) / $signed(b);
            end
            4'h5: return (b == 0) ? '1 : a / b;
            4'h6: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return 64'd0;
                return $signed(a) % $signed(b);
            end
            4'h7: return (b == 0) ? a : a % b;
            4'h8: r32 = a32 * b32;
            4'hC: begin
                if (b32 == 0) r32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                else r32 = $signed(a32) / $signed(b32);
            end
            4'hD: r32 = (b32 == 0) ? '1 : a32 / b32;
            4'hE: begin
                if (b32 == 0) r32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                else r32 = $signed(a32) % $signed(b32);
            end
            4'hF: r32 = (b32 == 0) ? a32 : a32 % b32;
            default: return 64'd0;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = o[3] ? 32 : 64;
`ifdef MDU_EARLY_OUT_EN
        if (!(o[3] && !o[2] && o[1:0] != 2'b00)) begin
            if (o[3] ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0)) return 2;
        end
`endif
        return n + 2;
    endfunction

    function automatic logic [63:0] rnd_val();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = MIN64;
            3:       v = 64'h0000_0000_8000_0000;
            4:       begin v = 64'($urandom_range(1, 9)); if ($urandom_range(0, 1) == 1) v = -v; end
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        int lat;
        logic [63:0] exp;
        exp = model(o, a, b);
        @(negedge clk);
        check({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        op = o; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, ":latency"}, 64'(lat), 64'(exp_lat(o, a, b)));
        check({tag, ":result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ":hold_result"}, result, exp);
            check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, ":release"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        int  saw;
        logic [3:0] ro;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset_result", result, 64'd0);
        @(negedge clk) rst = 1'b0;

        run_op("mul_7x-3", 4'h0, 64'd7, -64'd3, 10);
        run_op("mulhu_max", 4'h3, '1, '1, 0);
        run_op("mulhsu_-1x2", 4'h2, '1, 64'd2, 0);
        run_op("div_-7/2", 4'h4, -64'd7, 64'd2, 0);
        run_op("rem_-7/2", 4'h6, -64'd7, 64'd2, 0);
        run_op("div_5/0", 4'h4, 64'd5, 64'd0, 0);
        run_op("remu_5/0", 4'h7, 64'd5, 64'd0, 0);
        run_op("div_ovf", 4'h4, MIN64, '1, 0);
        run_op("rem_ovf", 4'h6, MIN64, '1, 0);
        run_op("divw_ovf", 4'hC, 64'h0000_0000_8000_0000, '1, 0);
        run_op("mulw_max", 4'h8, 64'h0000_0000_7FFF_FFFF, 64'd2, 0);
        run_op("illegal_w", 4'h9, 64'd3, 64'd4, 0);

        // Flush a divide mid-iteration.
        @(negedge clk);
        op = 4'h4; op_a = 64'd1000; op_b = 64'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_state", 64'({in_ready, out_valid, busy}), 64'b100);
        saw = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (out_valid) saw = 1;
        end
        check("flush_no_valid", 64'(saw), 64'd0);

        // Asynchronous reset mid-iteration.
        @(negedge clk);
        op = 4'h0; op_a = 64'd123; op_b = 64'd456; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({in_ready, out_valid, busy}), 64'b100);
        check("rst_mid_result", result, 64'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            run_op("random", ro, rnd_val(), rnd_val(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
